instr_mem_sync: RTL
===================

INSTR_MEM_SYNC -- requirements
Module: instr_mem_sync

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, meaning PC/address width in bits.
REQ-002 SHALL have parameter DEPTH_BYTES, default 65536, meaning byte capacity; a power of two and at least 4.
REQ-003 SHALL have parameter ALIGN_CHECK, default 1, meaning 1 enables the misalignment fault and 0 allows any byte address.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-006 SHALL have port req_valid  input  1  fetch request present.
REQ-007 SHALL have port req_ready  output  1  fetch request accepted this cycle when high with req_valid.
REQ-008 SHALL have port pc  input  ADDR_W  fetch byte address.
REQ-009 SHALL have port resp_valid  output  1  response held in output register.
REQ-010 SHALL have port resp_ready  input  1  consumer takes the response.
REQ-011 SHALL have port instr  output  32  fetched instruction, little-endian.
REQ-012 SHALL have port fault_misaligned  output  1  response pc[1:0] was not 0 and ALIGN_CHECK=1.
REQ-013 SHALL have port fault_range  output  1  response pc+3 was at or above DEPTH_BYTES.
REQ-014 SHALL have port ld_en  input  1  program-load byte write strobe.
REQ-015 SHALL have port ld_addr  input  ADDR_W  load byte address.
REQ-016 SHALL have port ld_data  input  8  load byte.
REQ-017 SHALL have port fetch_count  output  32  number of accepted fetches.

Function
REQ-018 SHALL store DEPTH_BYTES bytes, addressed by byte.
REQ-019 SHALL form instr as {mem[pc+3], mem[pc+2], mem[pc+1], mem[pc]}.
REQ-020 SHALL drive req_ready = !reset && !ld_en && (!resp_valid || resp_ready), combinationally.
REQ-021 SHALL define a fetch as accepted when req_valid && req_ready at a rising edge.
REQ-022 SHALL, for an accepted fetch, present resp_valid=1 with instr and both faults on the next cycle (latency 1).
REQ-023 SHALL hold instr, faults and resp_valid stable while resp_valid && !resp_ready.
REQ-024 SHALL clear resp_valid when resp_ready=1 and no fetch is accepted in the same cycle.
REQ-025 SHALL, when a response is taken and a new fetch is accepted in the same cycle, load the new response with no bubble, sustaining 1 fetch per cycle.
REQ-026 SHALL, on a fault, set the fault flag and drive instr=32'h0000_0013 (NOP) instead of memory data.
REQ-027 SHALL give fault_range priority over fault_misaligned, so that only one flag is ever set.
REQ-028 SHALL write ld_data to mem[ld_addr] on a rising edge when ld_en=1 and ld_addr < DEPTH_BYTES.
REQ-029 SHALL ignore a load with ld_addr >= DEPTH_BYTES.
REQ-030 SHALL give loads priority over fetches: req_ready is 0 while ld_en=1, and a response already buffered is unaffected by later loads.
REQ-031 SHALL increment fetch_count on every accepted fetch, saturating at 32'hFFFF_FFFF.
REQ-032 SHALL compute the range check without overflow, treating pc > DEPTH_BYTES-4 as a fault, including when pc is near 2^ADDR_W-1.
REQ-033 SHALL contain no combinational path from pc to instr.

Reset
REQ-034 SHALL, while reset=1, force resp_valid=0, instr=0, fault_misaligned=0, fault_range=0, fetch_count=0 and req_ready=0.
REQ-035 SHALL, on reset mid-operation, discard any pending response and ignore a same-cycle fetch; loads with ld_en=1 during reset still write.
REQ-036 SHALL NOT clear memory contents on reset.

Verification
REQ-037 Load bytes B3,04,5A,01 at 0x0-0x3, fetch pc=0 -> one cycle later resp_valid=1, instr=0x015A04B3, no faults, fetch_count=1.
REQ-038 Back-to-back fetches of pc=0,4,8 with resp_ready=1 -> three consecutive valid responses in address order, no bubbles, fetch_count=3.
REQ-039 Fetch with resp_ready=0 for 3 cycles -> instr held constant, req_ready=0, second request not accepted until resp_ready=1.
REQ-040 Fetch pc=0x2 (ALIGN_CHECK=1) -> fault_misaligned=1, instr=0x00000013; fetch pc=DEPTH_BYTES-2 -> fault_range=1 only.
REQ-041 Assert ld_en with req_valid=1 -> req_ready=0 and the load is written; the following fetch returns the new byte.
REQ-042 Assert reset while resp_valid=1 -> resp_valid=0, fetch_count=0 next cycle; previously loaded memory is still readable after reset.

Source files
------------

// File: rtl/instr_mem_sync.sv
// rtl/instr_mem_sync.sv - byte-addressed instruction memory with a registered one-deep fetch response
module instr_mem_sync #(
  parameter int ADDR_W      = 64,
  parameter int DEPTH_BYTES = 65536,
  parameter int ALIGN_CHECK = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] pc,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       instr,
  output logic              fault_misaligned,
  output logic              fault_range,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic [31:0]       fetch_count
);

  localparam int               IDX_W   = $clog2(DEPTH_BYTES);
  localparam logic [IDX_W-1:0] LAST_OK = IDX_W'(DEPTH_BYTES - 4);
  localparam logic [31:0]      NOP     = 32'h0000_0013;

  logic [7:0] mem [DEPTH_BYTES];

  logic        resp_valid_q, resp_valid_d;
  logic [31:0] instr_q, instr_d;
  logic        fault_mis_q, fault_mis_d;
  logic        fault_rng_q, fault_rng_d;
  logic [31:0] count_q, count_d;

  logic [IDX_W-1:0] pc_idx;
  logic             pc_hi, pc_rng, pc_mis, ld_in_range, accept;

  // Range test split into "above the index field" and "within the last word", so no pc+3 is ever formed.
  assign pc_idx      = pc[IDX_W-1:0];
  assign pc_hi       = (pc >> IDX_W) != '0;
  assign pc_rng      = pc_hi || (pc_idx > LAST_OK);
  assign pc_mis      = (ALIGN_CHECK != 0) && (pc_idx[1:0] != 2'b00) && !pc_rng;
  assign ld_in_range = (ld_addr >> IDX_W) == '0;

  assign req_ready = !reset && !ld_en && (!resp_valid_q || resp_ready);
  assign accept    = req_valid && req_ready;

  always_comb begin
    resp_valid_d = resp_valid_q;
    instr_d      = instr_q;
    fault_mis_d  = fault_mis_q;
    fault_rng_d  = fault_rng_q;
    count_d      = count_q;
    if (accept) begin
      resp_valid_d = 1'b1;
      fault_mis_d  = pc_mis;
      fault_rng_d  = pc_rng;
      if (pc_rng || pc_mis) begin
        instr_d = NOP;
      end else begin
        instr_d = {mem[pc_idx + IDX_W'(3)], mem[pc_idx + IDX_W'(2)],
                   mem[pc_idx + IDX_W'(1)], mem[pc_idx]};
      end
      if (count_q != 32'hFFFF_FFFF) begin
        count_d = count_q + 32'd1;
      end
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      instr_q      <= '0;
      fault_mis_q  <= 1'b0;
      fault_rng_q  <= 1'b0;
      count_q      <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      instr_q      <= instr_d;
      fault_mis_q  <= fault_mis_d;
      fault_rng_q  <= fault_rng_d;
      count_q      <= count_d;
    end
  end

  // Program load is independent of reset so images can be written while the core is held.
  always_ff @(posedge clk) begin
    if (ld_en && ld_in_range) begin
      mem[ld_addr[IDX_W-1:0]] <= ld_data;
    end
  end

  assign resp_valid       = resp_valid_q && !reset;
  assign instr            = reset ? 32'h0 : instr_q;
  assign fault_misaligned = fault_mis_q && !reset;
  assign fault_range      = fault_rng_q && !reset;
  assign fetch_count      = reset ? 32'h0 : count_q;

endmodule
